// File: rtl/uart_tx_frame_ctrl_pkg.sv
// Shared UART definitions: character/frame configuration encodings,
// line levels, transmit FSM state, debug view and a config legality check.
package UartGlobalPkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    DATA_5 = 4'd5,
    DATA_6 = 4'd6,
    DATA_7 = 4'd7,
    DATA_8 = 4'd8
  } DATA_TYPE_E;

  typedef enum logic {
    EVEN_PARITY = 1'b0,
    ODD_PARITY  = 1'b1
  } PARITY_TYPE_E;

  typedef enum logic [1:0] {
    STOP_1 = 2'd1,
    STOP_2 = 2'd2
  } STOP_BIT_E;

  typedef enum logic [4:0] {
    OVS_13 = 5'd13,
    OVS_16 = 5'd16
  } OVER_SMPLING_E;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Observation port: FSM state plus the bit-timing strobes driving it.
  typedef struct packed {
    tx_state_e state;
    logic      tick;
    logic      bitEnd;
  } tx_dbg_t;

  // 1 when the character-format part of a configuration is unusable.
  function automatic logic frame_cfg_illegal(input logic [3:0] w,
                                             input logic [1:0] s,
                                             input logic [4:0] os);
    logic bad_w;
    logic bad_s;
    logic bad_os;
    bad_w  = (w < DATA_5) || (w > DATA_8);
    bad_s  = (s != STOP_1) && (s != STOP_2);
    bad_os = (os != OVS_13) && (os != OVS_16);
    return bad_w | bad_s | bad_os;
  endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_baud_tick_gen.sv
// Bit timing for the transmitter: a clock divider producing oversample
// ticks and an oversample counter producing the end-of-bit strobe.
// bitEndNext predicts bitEnd one cycle ahead so the parent can register
// outputs that must line up with the last cycle of a bit.
module uart_baud_tick_gen
#(
  parameter int DIV_WIDTH = 16
)
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] baudDiv,
  input  logic [4:0]           overSample,
  output logic                 tick,
  output logic                 bitEnd,
  output logic                 bitEndNext
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] divCnt_q, divCnt_d, divLast;
  logic [4:0]           smpCnt_q, smpCnt_d, smpLast;

  assign divLast = baudDiv - DIV_ONE;
  assign smpLast = overSample - 5'd1;

  // Strobes from current counts; next counts with clear taking priority.
  always_comb begin
    tick     = run && (divCnt_q == divLast);
    bitEnd   = tick && (smpCnt_q == smpLast);
    divCnt_d = divCnt_q;
    smpCnt_d = smpCnt_q;
    if (clear) begin
      divCnt_d = '0;
      smpCnt_d = '0;
    end else if (run) begin
      if (tick) begin
        divCnt_d = '0;
        smpCnt_d = (smpCnt_q == smpLast) ? 5'd0 : smpCnt_q + 5'd1;
      end else begin
        divCnt_d = divCnt_q + DIV_ONE;
      end
    end
    bitEndNext = (divCnt_d == divLast) && (smpCnt_d == smpLast);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divCnt_q <= '0;
      smpCnt_q <= '0;
    end else begin
      divCnt_q <= divCnt_d;
      smpCnt_q <= smpCnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framer: accepts one character per valid/ready handshake and
// serialises start, 5-8 data bits LSB first, optional parity and 1-2 stop
// bits. Every state lasts one bit period (cfgBaudDiv * cfgOverSample clocks).
//
// Handshake: a character is transferred on a rising edge where txValid and
// txReady are both 1. txValid may rise or fall freely while txReady is 0;
// txData and cfg* are sampled only at the transfer edge. txReady is offered
// in IDLE and during the last cycle of the last stop bit, so a held txValid
// produces contiguous frames.
module uart_tx_frame_ctrl
  import UartGlobalPkg::*;
#(
  parameter int DATA_WIDTH = UartGlobalPkg::DATA_WIDTH,
  parameter int DIV_WIDTH  = 16
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  txValid,
  output logic                  txReady,
  input  logic [DATA_WIDTH-1:0] txData,
  input  logic [3:0]            cfgDataWidth,
  input  logic                  cfgParityEn,
  input  logic                  cfgParityType,
  input  logic [1:0]            cfgStopBits,
  input  logic [4:0]            cfgOverSample,
  input  logic [DIV_WIDTH-1:0]  cfgBaudDiv,
  output logic                  txSerial,
  output logic                  txBusy,
  output logic                  frameDone,
  output logic                  cfgError,
  output tx_dbg_t               dbg
);

  localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ALL = '1;

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            width_q, width_d;
  logic                  parEn_q, parEn_d;
  logic                  parOdd_q, parOdd_d;
  logic [1:0]            stops_q, stops_d;
  logic [4:0]            os_q, os_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [3:0]            bitIdx_q, bitIdx_d;
  logic [1:0]            stopIdx_q, stopIdx_d;
  logic                  txSerial_q, txSerial_d;
  logic                  txReady_q, txReady_d;
  logic                  frameDone_q, frameDone_d;

  logic                  accept;
  logic                  runBaud;
  logic                  tick;
  logic                  bitEnd;
  logic                  bitEndNext;
  logic                  lastStopNext;
  logic [DATA_WIDTH-1:0] dataMask;
  logic                  dataBit;

  assign cfgError  = frame_cfg_illegal(cfgDataWidth, cfgStopBits, cfgOverSample)
                     || (cfgBaudDiv == '0);
  assign txReady   = txReady_q & ~cfgError;
  assign accept    = txValid & txReady;
  assign runBaud   = (state_q != TX_IDLE);
  assign txSerial  = txSerial_q;
  assign txBusy    = (state_q != TX_IDLE);
  assign frameDone = frameDone_q;
  assign dbg       = '{state: state_q, tick: tick, bitEnd: bitEnd};

  uart_baud_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .run        (runBaud),
    .baudDiv    (div_q),
    .overSample (os_q),
    .tick       (tick),
    .bitEnd     (bitEnd),
    .bitEndNext (bitEndNext)
  );

  // Next state, frame indices, captured character and registered outputs.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    width_d     = width_q;
    parEn_d     = parEn_q;
    parOdd_d    = parOdd_q;
    stops_d     = stops_q;
    os_d        = os_q;
    div_d       = div_q;
    bitIdx_d    = bitIdx_q;
    stopIdx_d   = stopIdx_q;

    case (state_q)
      TX_IDLE: ;
      TX_START: begin
        if (bitEnd) begin
          state_d  = TX_DATA;
          bitIdx_d = 4'd0;
        end
      end
      TX_DATA: begin
        if (bitEnd) begin
          if (bitIdx_q == width_q - 4'd1) begin
            state_d   = parEn_q ? TX_PARITY : TX_STOP;
            stopIdx_d = 2'd0;
          end else begin
            bitIdx_d = bitIdx_q + 4'd1;
          end
        end
      end
      TX_PARITY: begin
        if (bitEnd) begin
          state_d   = TX_STOP;
          stopIdx_d = 2'd0;
        end
      end
      TX_STOP: begin
        if (bitEnd) begin
          if (stopIdx_q == stops_q - 2'd1) begin
            state_d = TX_IDLE;
          end else begin
            stopIdx_d = stopIdx_q + 2'd1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // A transfer starts a fresh frame, including straight out of the last stop bit.
    if (accept) begin
      state_d   = TX_START;
      data_d    = txData;
      width_d   = cfgDataWidth;
      parEn_d   = cfgParityEn;
      parOdd_d  = (cfgParityType == ODD_PARITY);
      stops_d   = cfgStopBits;
      os_d      = cfgOverSample;
      div_d     = cfgBaudDiv;
      bitIdx_d  = 4'd0;
      stopIdx_d = 2'd0;
    end

    lastStopNext = (state_d == TX_STOP) && (stopIdx_d == stops_d - 2'd1) && bitEndNext;
    txReady_d    = (state_d == TX_IDLE) || lastStopNext;
    frameDone_d  = lastStopNext;

    dataMask = ~(DATA_ALL << width_d);
    dataBit  = |(data_d & (DATA_ONE << bitIdx_d));
    case (state_d)
      TX_START:  txSerial_d = START_BIT;
      TX_DATA:   txSerial_d = dataBit;
      TX_PARITY: txSerial_d = parOdd_d ^ (^(data_d & dataMask));
      default:   txSerial_d = STOP_BIT;
    endcase
  end

  // State and datapath registers; reset forces the line idle and drops any frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= TX_IDLE;
      data_q      <= '0;
      width_q     <= 4'd8;
      parEn_q     <= 1'b0;
      parOdd_q    <= 1'b0;
      stops_q     <= 2'd1;
      os_q        <= 5'd16;
      div_q       <= DIV_WIDTH'(1);
      bitIdx_q    <= 4'd0;
      stopIdx_q   <= 2'd0;
      txSerial_q  <= STOP_BIT;
      txReady_q   <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      width_q     <= width_d;
      parEn_q     <= parEn_d;
      parOdd_q    <= parOdd_d;
      stops_q     <= stops_d;
      os_q        <= os_d;
      div_q       <= div_d;
      bitIdx_q    <= bitIdx_d;
      stopIdx_q   <= stopIdx_d;
      txSerial_q  <= txSerial_d;
      txReady_q   <= txReady_d;
      frameDone_q <= frameDone_d;
    end
  end

endmodule
